seq_det_ctrl: RTL and testbench

Configurable Moore serial-pattern detector with a configuration handshake, run/idle sequencing and a match counter. It generalises the fixed "101" Moore detector: software/bench loads a pattern (1..MAX_LEN bits), a length and an overlap mode, then the block scans the serial `din` stream. It sits between the serial input pin and the status/interrupt logic that consumes `Y` and `match_count`.

---
 rtl/seq_det_pkg.sv | 12 +
 rtl/seq_match_core.sv | 37 +++
 rtl/seq_det_ctrl.sv | 77 +++++++
 tb/tb_seq_det_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared state encoding, default sizes and the length-mask helper for the pattern detector.
package seq_det_pkg;
  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;
  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_LEN_W = 4;
  localparam int DEF_CNT_W = 8;
  // Wide enough for the largest supported pattern; callers truncate to their own MAX_LEN.
  localparam int MASK_W = 16;
  function automatic logic [MASK_W-1:0] mask(input logic [4:0] len);
    return (len >= 5'(MASK_W)) ? '1 : (MASK_W'(1) << len) - MASK_W'(1);
  endfunction
endpackage

// File: rtl/seq_match_core.sv
// seq_match_core: serial history shifter, fill counter and length-masked pattern comparator.
module seq_match_core
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               shift_en,
  input  logic               clr_fill,
  input  logic               clr_all,
  input  logic               din,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               hit
);
  // Only MAX_LEN-1 past bits are stored; the incoming bit completes the window.
  logic [MAX_LEN-2:0] hist_q;
  logic [MAX_LEN-1:0] hist_d, msk;
  logic [LEN_W-1:0]   fill_q, fill_d;
  always_comb begin
    hist_d = {hist_q, din};
    fill_d = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
    msk = MAX_LEN'(mask(5'(len)));
    hit = shift_en && (fill_d >= len) && (((hist_d ^ pattern) & msk) == '0);
  end
  always_ff @(posedge CLK) begin
    if (RST || clr_all) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (shift_en) begin
      hist_q <= hist_d[MAX_LEN-2:0];
      fill_q <= clr_fill ? '0 : fill_d;
    end
  end
endmodule

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: configurable Moore serial-pattern detector with config handshake, run sequencing and match counter.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W = DEF_LEN_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               enable,
  input  logic               din,
  output logic               Y,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err,
  output logic               running
);
  state_t state_q, state_d;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ov_q, err_q, y_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               xfer, len_ok, arm, shift_en, hit;
  assign len_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
  always_ff @(posedge CLK) state_q <= RST ? IDLE : state_d;
  always_comb begin
    state_d = (state_q == ARM) ? RUN :
              xfer ? (len_ok ? ARM : IDLE) :
              (state_q == RUN) ? RUN : IDLE;
  end
  // The din bit at an accepting edge is dropped, which also forces Y low next cycle.
  always_comb begin
    cfg_ready = state_q != ARM;
    running = state_q == RUN;
    arm = state_q == ARM;
    xfer = cfg_valid && cfg_ready;
    shift_en = running && enable && !xfer;
  end
  seq_match_core #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_core (
    .CLK      (CLK),
    .RST      (RST),
    .shift_en (shift_en),
    .clr_fill (hit && !ov_q),
    .clr_all  (arm),
    .din      (din),
    .pattern  (pat_q),
    .len      (len_q),
    .hit      (hit)
  );
  always_ff @(posedge CLK) begin
    if (RST) begin
      pat_q <= '0;
      len_q <= '0;
      ov_q <= 1'b0;
      err_q <= 1'b0;
      y_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      y_q <= hit;
      cnt_q <= (xfer || arm) ? '0 : (hit && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
      if (xfer) begin
        pat_q <= cfg_pattern;
        len_q <= cfg_len;
        ov_q <= cfg_overlap;
        err_q <= !len_ok;
      end
    end
  end
  assign Y = y_q;
  assign match_count = cnt_q;
  assign cfg_err = err_q;
endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb_seq_det_ctrl: table-driven directed checks of the configurable pattern detector, plus saturation/reconfig sequences.
module tb_seq_det_ctrl;
  logic       CLK = 1'b0;
  logic       RST, cfg_valid, cfg_overlap, enable, din;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_ready, Y, cfg_err, running;
  logic [7:0] match_count;
  logic       s_ready, s_y, s_err, s_run;
  logic [1:0] s_cnt;
  int total = 0, bad = 0;

  always #5 CLK = ~CLK;

  seq_det_ctrl dut (
    .CLK(CLK), .RST(RST), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .enable(enable), .din(din), .Y(Y), .match_count(match_count),
    .cfg_err(cfg_err), .running(running)
  );

  seq_det_ctrl #(.CNT_W(2)) dut_s (
    .CLK(CLK), .RST(RST), .cfg_valid(cfg_valid), .cfg_ready(s_ready),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .enable(enable), .din(din), .Y(s_y), .match_count(s_cnt),
    .cfg_err(s_err), .running(s_run)
  );

  typedef struct {
    logic rst, cv;
    logic [7:0] pat;
    logic [3:0] len;
    logic ov, en, d, y;
    logic [7:0] cnt;
    logic err, run, rdy;
  } vec_t;
  vec_t v[$];

  function automatic void add(int r, int cv, int p, int l, int ov, int en, int d,
                              int y, int c, int er, int ru, int rd);
    vec_t t;
    t.rst = 1'(r); t.cv = 1'(cv); t.pat = 8'(p); t.len = 4'(l); t.ov = 1'(ov);
    t.en = 1'(en); t.d = 1'(d); t.y = 1'(y); t.cnt = 8'(c); t.err = 1'(er);
    t.run = 1'(ru); t.rdy = 1'(rd);
    v.push_back(t);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic cv, input logic [7:0] p, input logic [3:0] l,
                       input logic ov, input logic en, input logic d);
    RST = r; cfg_valid = cv; cfg_pattern = p; cfg_len = l; cfg_overlap = ov; enable = en; din = d;
    @(posedge CLK);
    #1;
  endtask

  task automatic stream(input logic [10:0] s, input logic [10:0] e, input int n);
    int c = 0;
    for (int i = n - 1; i >= 0; i--) begin
      c += int'(e[i]);
      add(0, 0, 0, 0, 0, 1, int'(s[i]), int'(e[i]), c, 0, 1, 1);
    end
  endtask

  initial begin
    // reset state
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // overlapping "101"
    add(0, 1, 'b101, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    stream(11'b10110101101, 11'b00100101001, 11);
    // reconfig in RUN to non-overlapping "101"; din at the accepting edge is dropped
    add(0, 1, 'b101, 3, 0, 1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1);
    stream(11'b10110101101, 11'b00100100001, 11);
    // illegal lengths 0 and 9
    add(0, 1, 'hFF, 0, 1, 1, 1, 0, 0, 1, 0, 1);
    add(0, 1, 'hFF, 9, 1, 1, 1, 0, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 1);
    // legal "11" overlapping: back-to-back hits
    add(0, 1, 'b11, 2, 1, 1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1);
    stream(11'b1111, 11'b0111, 4);
    add(0, 0, 0, 0, 0, 0, 1, 0, 3, 0, 1, 1);
    // "11" non-overlapping: stale history must not hit while fill < len
    add(0, 1, 'b11, 2, 0, 1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1);
    stream(11'b1111, 11'b0101, 4);
    add(0, 0, 0, 0, 0, 1, 1, 0, 2, 0, 1, 1);
    add(0, 0, 0, 0, 0, 1, 1, 1, 3, 0, 1, 1);
    // reset mid-RUN with din toggling, then reset beats a pending config
    add(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 1, i % 2, 0, 0, 0, 0, 1);
    add(1, 1, 'b1, 1, 1, 1, 1, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1);

    foreach (v[i]) begin
      drive(v[i].rst, v[i].cv, v[i].pat, v[i].len, v[i].ov, v[i].en, v[i].d);
      chk($sformatf("v%0d_y", i), int'(Y), int'(v[i].y));
      chk($sformatf("v%0d_cnt", i), int'(match_count), int'(v[i].cnt));
      chk($sformatf("v%0d_err", i), int'(cfg_err), int'(v[i].err));
      chk($sformatf("v%0d_run", i), int'(running), int'(v[i].run));
      chk($sformatf("v%0d_rdy", i), int'(cfg_ready), int'(v[i].rdy));
    end

    // len=1 pattern 1, six enabled ones with enable gaps; the 2-bit counter saturates at 3
    begin
      logic [7:0] en_seq;
      logic [7:0] y_seq;
      int c8 = 0, c2 = 0;
      en_seq = 8'b11010111;
      y_seq = 8'b11010111;
      drive(0, 1, 8'b1, 1, 1, 0, 0);
      chk("sat_arm_rdy", int'(s_ready), 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("sat_run", int'(s_run), 1);
      for (int i = 7; i >= 0; i--) begin
        drive(0, 0, 0, 0, 0, en_seq[i], 1);
        if (y_seq[i]) begin
          c8++;
          if (c2 < 3) c2++;
        end
        chk($sformatf("sat%0d_y", i), int'(s_y), int'(y_seq[i]));
        chk($sformatf("sat%0d_cnt2", i), int'(s_cnt), c2);
        chk($sformatf("sat%0d_cnt8", i), int'(match_count), c8);
      end
      // reconfig in RUN: one ARM cycle with cfg_ready low and counts cleared
      drive(0, 1, 8'b0, 1, 1, 1, 1);
      chk("rc_rdy", int'(s_ready), 0);
      chk("rc_run", int'(s_run), 0);
      chk("rc_cnt2", int'(s_cnt), 0);
      chk("rc_cnt8", int'(match_count), 0);
      chk("rc_y", int'(s_y), 0);
      drive(0, 0, 0, 0, 0, 1, 0);
      chk("rc_rdy2", int'(s_ready), 1);
      chk("rc_run2", int'(s_run), 1);
      chk("rc_y2", int'(s_y), 0);
      drive(0, 0, 0, 0, 0, 1, 0);
      chk("rc_hit_y", int'(s_y), 1);
      chk("rc_hit_cnt", int'(s_cnt), 1);
      drive(0, 0, 0, 0, 0, 1, 1);
      chk("rc_miss_y", int'(s_y), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
